// File: rtl/do_binarize_mean_pkg.sv
// rtl/do_binarize_mean_pkg.sv - shared constants and state encoding for the do_* filter stages
package do_binarize_mean_pkg;

  localparam int NUM_PIXELS = 76800;
  localparam int ADDR_W     = 17;
  localparam int PIX_W      = 12;
  localparam int SUM_W      = 21;

  localparam logic [PIX_W-1:0] WHITE = 12'hFFF;
  localparam logic [PIX_W-1:0] BLACK = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_SUM_FLUSH,
    ST_BIN,
    ST_BIN_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/do_binarize_mean_buf2_addr_sweep.sv
// rtl/do_binarize_mean_buf2_addr_sweep.sv - one-shot 0..NUM_PIXELS-1 address sweep over frame buffer 2
module buf2_addr_sweep #(
  parameter int NUM_PIXELS = do_binarize_mean_pkg::NUM_PIXELS,
  parameter int ADDR_W     = do_binarize_mean_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] wraddr_o,
  output logic              last_o,
  output logic              rd_vld_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wraddr_q;
  logic              rd_vld_q;

  assign last_o   = active_q && (addr_q == LAST_ADDR);
  assign addr_o   = addr_q;
  assign wraddr_o = wraddr_q;
  assign rd_vld_o = rd_vld_q;

  // The counter parks at 0 after the last address so it never runs past the frame.
  always_comb begin
    addr_d   = addr_q;
    active_d = active_q;
    if (start_i) begin
      addr_d   = '0;
      active_d = 1'b1;
    end else if (last_o) begin
      addr_d   = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      wraddr_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      rd_vld_q <= active_q;
      if (active_q) wraddr_q <= addr_q;
    end
  end

endmodule

// File: rtl/do_binarize_mean.sv
// rtl/do_binarize_mean.sv - two-pass in-place mean threshold of frame buffer 2
module do_binarize_mean #(
  parameter int NUM_PIXELS = do_binarize_mean_pkg::NUM_PIXELS,
  parameter int ADDR_W     = do_binarize_mean_pkg::ADDR_W,
  parameter int PIX_W      = do_binarize_mean_pkg::PIX_W,
  parameter int SUM_W      = do_binarize_mean_pkg::SUM_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_filter,
  output logic              led_done,
  output logic [ADDR_W-1:0] rdaddr_buf2,
  input  logic [PIX_W-1:0]  din_buf2,
  output logic [ADDR_W-1:0] wraddr_buf2,
  output logic [PIX_W-1:0]  dout_buf2,
  output logic              we_buf2
);
  import do_binarize_mean_pkg::*;

  localparam logic [SUM_W-1:0] NPIX_S = SUM_W'(NUM_PIXELS);

  state_e           state_q;
  logic [SUM_W-1:0] sum_q;
  logic             led_done_q;

  logic             sweep_start;
  logic             sweep_last;
  logic             rd_vld;
  logic [3:0]       grey;
  logic [SUM_W-1:0] grey_scaled;
  logic             unused_hi;

  assign grey      = din_buf2[3:0];
  assign unused_hi = ^din_buf2[PIX_W-1:4];

  // Restart the sweep on a run start and again between the two passes.
  assign sweep_start = ((state_q == ST_IDLE) && enable_filter) || (state_q == ST_SUM_FLUSH);

  buf2_addr_sweep #(
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_W    (ADDR_W)
  ) u_sweep (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (sweep_start),
    .addr_o  (rdaddr_buf2),
    .wraddr_o(wraddr_buf2),
    .last_o  (sweep_last),
    .rd_vld_o(rd_vld)
  );

  // grey > sum/N rewritten as grey*N > sum, so no divider is needed.
  assign grey_scaled = SUM_W'(grey) * NPIX_S;
  assign we_buf2     = rd_vld && ((state_q == ST_BIN) || (state_q == ST_BIN_FLUSH));
  assign dout_buf2   = (we_buf2 && (grey_scaled > sum_q)) ? WHITE : BLACK;
  assign led_done    = led_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      led_done_q <= 1'b0;
    end else begin
      led_done_q <= (state_q == ST_DONE);
      if (rd_vld && ((state_q == ST_SUM) || (state_q == ST_SUM_FLUSH)))
        sum_q <= sum_q + SUM_W'(grey);
      case (state_q)
        ST_IDLE: begin
          if (enable_filter) begin
            sum_q   <= '0;
            state_q <= ST_SUM;
          end
        end
        ST_SUM:       if (sweep_last) state_q <= ST_SUM_FLUSH;
        ST_SUM_FLUSH: state_q <= ST_BIN;
        ST_BIN:       if (sweep_last) state_q <= ST_BIN_FLUSH;
        ST_BIN_FLUSH: state_q <= ST_DONE;
        ST_DONE:      if (!enable_filter) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
